// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and FSM state encoding for the
// ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;

  // resp_flag = {neg, zero, carry, overflow}
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALUComponent.sv
// Combinational N-bit ALU. Carry is the carry-out for ADD, the borrow for SUB
// and "upper product half nonzero" for MUL; overflow is signed overflow for
// ADD/SUB. Unassigned opcodes (110/111) fall back to ADD.
module ALUComponent
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   sel_i,
  output logic [N-1:0] out_o,
  output logic [3:0]   flag_o
);

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [2*N-1:0] prod;
  logic [N-1:0]   res;
  logic           carry;
  logic           ovf;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};

  // Opcode decode: result plus carry/overflow, then derive neg/zero.
  always_comb begin
    res   = sum[N-1:0];
    carry = sum[N];
    ovf   = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
    case (sel_i)
      OP_ADD: begin
        res   = sum[N-1:0];
        carry = sum[N];
        ovf   = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        res   = diff[N-1:0];
        carry = diff[N];
        ovf   = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
      end
      OP_AND: begin
        res   = a_i & b_i;
        carry = 1'b0;
        ovf   = 1'b0;
      end
      OP_OR: begin
        res   = a_i | b_i;
        carry = 1'b0;
        ovf   = 1'b0;
      end
      OP_MUL: begin
        res   = prod[N-1:0];
        carry = |prod[2*N-1:N];
        ovf   = 1'b0;
      end
      OP_PASSB: begin
        res   = b_i;
        carry = 1'b0;
        ovf   = 1'b0;
      end
      default: ;
    endcase
    out_o              = res;
    flag_o             = '0;
    flag_o[FLAG_NEG]   = res[N-1];
    flag_o[FLAG_ZERO]  = (res == '0);
    flag_o[FLAG_CARRY] = carry;
    flag_o[FLAG_OVF]   = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU. One operation
// in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it until
// the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [5:0]     req_sel,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [N-1:0]   resp_out,
  output logic [3:0]     resp_flag,
  output logic           resp_err,
  output logic [15:0]    op_count
);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2:0]     sel_q, sel_d;
  logic           id_q, id_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_id_q, resp_id_d;
  logic [N-1:0]   resp_out_q, resp_out_d;
  logic [3:0]     resp_flag_q, resp_flag_d;
  logic           resp_err_q, resp_err_d;
  logic [15:0]    op_count_q, op_count_d;

  logic           gnt_id;
  logic           accept;
  logic [N-1:0]   alu_out;
  logic [3:0]     alu_flag;

  // The ALU only ever sees the latched operands, never the live request bus.
  ALUComponent #(.N(N)) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .sel_i  (sel_q),
    .out_o  (alu_out),
    .flag_o (alu_flag)
  );

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    case (req_valid)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant_q;
      default: gnt_id = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == ST_IDLE && !rst)
      req_ready = req_valid & (gnt_id ? 2'b10 : 2'b01);
    accept = |req_ready;
  end

  // Next-state and datapath capture for IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_out_d   = resp_out_q;
    resp_flag_d  = resp_flag_q;
    resp_err_d   = resp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d          = gnt_id ? req_a[2*N-1:N] : req_a[N-1:0];
          b_d          = gnt_id ? req_b[2*N-1:N] : req_b[N-1:0];
          sel_d        = gnt_id ? req_sel[5:3]   : req_sel[2:0];
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_out_d   = alu_out;
        resp_flag_d  = alu_flag;
        resp_err_d   = (sel_q[2:1] == 2'b11);
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation and biases the
  // first tie toward requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_out_q   <= '0;
      resp_flag_q  <= '0;
      resp_err_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      resp_flag_q  <= resp_flag_d;
      resp_err_q   <= resp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_out   = resp_out_q;
  assign resp_flag  = resp_flag_q;
  assign resp_err   = resp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drives on the falling edge, samples on the
// falling edge, expected values hand-computed.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_sel;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_out;
  logic [3:0]  resp_flag;
  logic        resp_err;
  logic [15:0] op_count;

  int n_chk  = 0;
  int n_fail = 0;

  alu_arbiter #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .resp_flag  (resp_flag),
    .resp_err   (resp_err),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request from requester id; returns at the negedge where the
  // response should be visible (two cycles after the accepting edge).
  task automatic issue(input int id, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    logic [1:0] eg;
    eg = (id == 1) ? 2'b10 : 2'b01;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_sel[id*3 +: 3] = sel;
    req_valid          = eg;
    #1 chk("grant", 64'(req_ready), 64'(eg));
    @(negedge clk);
    req_valid = 2'b00;
    chk("exec_no_vld", 64'(resp_valid), 64'(0));
    chk("exec_no_rdy", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("lat_t2_vld", 64'(resp_valid), 64'(1));
    chk("resp_id", 64'(resp_id), 64'(id));
  endtask

  task automatic complete(input logic [15:0] exp_cnt);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("done_vld", 64'(resp_valid), 64'(0));
    chk("op_count", 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int nresp;
    logic [1:0] eg;

    rst        = 1'b1;
    req_valid  = 2'b11;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    resp_ready = 1'b0;

    // Reset state, and no ready while in reset even with both valid
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", 64'(req_ready), 64'(0));
    chk("rst_vld", 64'(resp_valid), 64'(0));
    chk("rst_cnt", 64'(op_count), 64'(0));
    chk("rst_out", 64'(resp_out), 64'(0));
    chk("rst_flag", 64'(resp_flag), 64'(0));
    chk("rst_err", 64'(resp_err), 64'(0));
    chk("rst_id", 64'(resp_id), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;

    // r0 ADD 5+3
    issue(0, OP_ADD, 32'd5, 32'd3);
    chk("add_out", 64'(resp_out), 64'(8));
    chk("add_flag", 64'(resp_flag), 64'(4'b0000));
    complete(16'd1);

    // r1 SUB 3-5 -> negative
    issue(1, OP_SUB, 32'd3, 32'd5);
    chk("sub_out", 64'(resp_out), 64'h0000_0000_FFFF_FFFE);
    chk("sub_neg", 64'(resp_flag[3]), 64'(1));
    complete(16'd2);

    // r0 OR with consumer stalled; r1 waits meanwhile
    issue(0, OP_OR, 32'hF0, 32'h0F);
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd1;
    req_valid    = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("stall_vld", 64'(resp_valid), 64'(1));
      chk("stall_out", 64'(resp_out), 64'hFF);
      chk("stall_id", 64'(resp_id), 64'(0));
      chk("stall_flag", 64'(resp_flag), 64'(0));
      chk("stall_rdy", 64'(req_ready), 64'(0));
    end
    complete(16'd3);
    #1 chk("rr_after_r0", 64'(req_ready), 64'(2'b10));
    // withdraw before acceptance: nothing should happen
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("withdraw_vld", 64'(resp_valid), 64'(0));
    chk("withdraw_cnt", 64'(op_count), 64'(3));
    @(negedge clk);
    chk("withdraw_vld2", 64'(resp_valid), 64'(0));

    // Reset pulsed while an op is in EXEC
    req_a[31:0] = 32'd1;
    req_b[31:0] = 32'd1;
    req_sel     = '0;
    req_valid   = 2'b01;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rstx_vld", 64'(resp_valid), 64'(0));
    chk("rstx_cnt", 64'(op_count), 64'(0));
    rst = 1'b0;

    // Both valid continuously from reset release: grants alternate 0,1,0,1
    req_a       = {32'd0, 32'd10};
    req_b       = {32'd7, 32'd1};
    req_sel     = {OP_PASSB, OP_ADD};
    req_valid   = 2'b11;
    resp_ready  = 1'b1;
    ngr         = 0;
    nresp       = 0;
    for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00 && ngr < 4) begin
        eg = (ngr % 2 == 0) ? 2'b01 : 2'b10;
        chk("alt_grant", 64'(req_ready), 64'(eg));
        ngr++;
      end
      if (resp_valid) begin
        chk("alt_id", 64'(resp_id), 64'(nresp % 2));
        chk("alt_out", 64'(resp_out), (nresp % 2 == 0) ? 64'd11 : 64'd7);
        nresp++;
      end
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    chk("alt_nresp", 64'(nresp), 64'(4));
    chk("alt_cnt", 64'(op_count), 64'(4));
    @(negedge clk);

    // Unassigned opcode -> add result with error
    issue(0, 3'b110, 32'd2, 32'd2);
    chk("err_bit", 64'(resp_err), 64'(1));
    chk("err_out", 64'(resp_out), 64'(4));
    chk("err_flag", 64'(resp_flag), 64'(0));
    complete(16'd5);

    // Flag boundaries
    issue(1, OP_SUB, 32'd5, 32'd5);
    chk("zero_out", 64'(resp_out), 64'(0));
    chk("zero_flag", 64'(resp_flag), 64'(4'b0100));
    chk("zero_err", 64'(resp_err), 64'(0));
    complete(16'd6);
    issue(0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("ovf_out", 64'(resp_out), 64'h8000_0000);
    chk("ovf_flag", 64'(resp_flag), 64'(4'b1001));
    complete(16'd7);
    issue(1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    chk("cy_out", 64'(resp_out), 64'(0));
    chk("cy_flag", 64'(resp_flag), 64'(4'b0110));
    complete(16'd8);
    issue(0, OP_AND, 32'hC, 32'hA);
    chk("and_out", 64'(resp_out), 64'(8));
    complete(16'd9);

    // op_count wrap from 0xFFFF
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1 chk("preload", 64'(op_count), 64'hFFFF);
    issue(1, OP_MUL, 32'd6, 32'd7);
    chk("mul_out", 64'(resp_out), 64'd42);
    chk("mul_err", 64'(resp_err), 64'(0));
    complete(16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning the operand and result width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 2; bit i means requester i presents an operation.
REQ-005 SHALL have port req_ready, output, 2; bit i means requester i's operation is accepted this cycle.
REQ-006 SHALL have port req_a, input, 2N, holding operand A with requester 0 in [N-1:0] and requester 1 in [2N-1:N].
REQ-007 SHALL have port req_b, input, 2N, holding operand B with the same packing as req_a.
REQ-008 SHALL have port req_sel, input, 6, holding the opcode, with requester 0 in [2:0] and requester 1 in [5:3].
REQ-009 SHALL have port resp_valid, output, 1, meaning a result is presented.
REQ-010 SHALL have port resp_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port resp_id, output, 1, giving the index of the requester that owns the result.
REQ-012 SHALL have port resp_out, output, N, the result value.
REQ-013 SHALL have port resp_flag, output, 4, the flags {neg, zero, carry, overflow} in bits [3:0].
REQ-014 SHALL have port resp_err, output, 1, set when the opcode was 110 or 111.
REQ-015 SHALL have port op_count, output, 16, the count of completed responses.

Function
REQ-016 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE, with exactly one operation in flight.
REQ-017 SHALL, in IDLE, drive req_ready only to the granted requester, and only when its req_valid=1; req_ready is combinational from req_valid and state.
REQ-018 SHALL grant round-robin when both requesters are valid: the requester not granted last wins; a lone valid requester wins immediately.
REQ-019 SHALL, on handshake (req_valid[i]&req_ready[i]), latch a, b, sel and id, update last_grant, and move to EXEC.
REQ-020 SHALL, in EXEC, apply the latched operands to the ALU, capture Out and flag into the response registers, set resp_err=(sel[2:1]==2'b11), and move to RESP.
REQ-021 SHALL present resp_valid=1 in RESP with all resp_* outputs held stable until resp_ready=1.
REQ-022 SHALL, on resp_valid&resp_ready, return to IDLE, clear resp_valid, and increment op_count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-023 SHALL have a latency from accept edge t to resp_valid=1 of exactly 2 cycles (t+2); minimum throughput is one operation per 3 cycles.
REQ-024 SHALL keep req_ready=0 in EXEC and RESP, so a requester valid during that time waits and is arbitrated on return to IDLE.
REQ-025 SHALL pass the ALU's Out and flag through unmodified for all opcodes; opcodes 110/111 produce the ALU default (add) result with resp_err=1.
REQ-026 SHALL allow req_valid to deassert before acceptance without any side effect.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, force state=IDLE, resp_valid=0, resp_id=0, resp_out=0, resp_flag=0, resp_err=0, op_count=0, and last_grant=1, so requester 0 wins the first tie.
REQ-028 SHALL discard any in-flight operation when reset is asserted in EXEC or RESP, with no response emitted afterwards.
REQ-029 SHALL hold req_ready=0 while rst=1.

Structure
REQ-030 SHALL place opcode constants (ADD=000, SUB=001, AND=010, OR=011, MUL=100, PASSB=101), flag bit indices, and the FSM state enum in the shared package alu_pkg.
REQ-031 SHALL contain exactly one sub-module: a single ALUComponent #(N) instance fed from the latched operand registers.

Verification
REQ-032 SHALL verify: r0 sends sel=000, a=5, b=3 -> at t+2 resp_valid=1, resp_id=0, resp_out=8, resp_flag=0000.
REQ-033 SHALL verify: r1 sends sel=001, a=3, b=5 -> resp_out=0xFFFFFFFE, resp_flag[3]=1, resp_id=1.
REQ-034 SHALL verify: both requesters are valid continuously from reset release -> grants alternate 0,1,0,1, op_count=4 after four responses.
REQ-035 SHALL verify: resp_ready is held low for 3 cycles -> resp_* stays stable, req_ready stays 0, and the response completes on the first resp_ready=1 cycle.
REQ-036 SHALL verify: rst is pulsed in EXEC -> next cycle resp_valid=0, op_count=0, and the next tie is granted to r0.
REQ-037 SHALL verify: sel=110, a=2, b=2 -> resp_err=1, resp_out=4; then op_count preloaded to 0xFFFF wraps to 0 after one response.
